led_fade: RTL and testbench

LED_FADE -- requirements
Module: led_fade

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_fade_if.sv | 26 ++
 rtl/led_fade_chan.sv | 69 ++++++
 rtl/led_fade.sv | 91 +++++++++
 tb/tb_led_fade.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED fader.
//   chan_state_e : per-channel ramp state (OFF, UP, ON, DOWN)
//   next_state() : state chosen from the post-update duty and the current target level
package led_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StUp   = 2'd1,
    StOn   = 2'd2,
    StDown = 2'd3
  } chan_state_e;

  function automatic chan_state_e next_state(logic at_zero, logic at_max, logic lvl);
    chan_state_e st;
    if (!lvl && at_zero) begin
      st = StOff;
    end else if (lvl && at_max) begin
      st = StOn;
    end else if (lvl) begin
      st = StUp;
    end else begin
      st = StDown;
    end
    return st;
  endfunction

endpackage

// File: rtl/led_fade_if.sv
// Control/status bundle of the LED fader.
//   en            : fade ticks advance when 1
//   lvl_r/g/b     : per-channel target level (1 = full on)
//   led_r/g/b     : PWM pin drive
//   busy          : any channel ramping
// master = controller side, slave = fader side.
interface led_fade_if;
  logic en;
  logic lvl_r;
  logic lvl_g;
  logic lvl_b;
  logic led_r;
  logic led_g;
  logic led_b;
  logic busy;

  modport master (
    output en, lvl_r, lvl_g, lvl_b,
    input  led_r, led_g, led_b, busy
  );

  modport slave (
    input  en, lvl_r, lvl_g, lvl_b,
    output led_r, led_g, led_b, busy
  );
endinterface

// File: rtl/led_fade_chan.sv
// One fader channel: saturating duty register, ramp state, PWM compare and
// registered pin drive.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : one-cycle fade step strobe
//   lvl_i         : target level (1 = ramp towards full on)
//   pwm_cnt_i     : shared free-running PWM counter
//   led_o         : registered pin drive (polarity set by ACTIVE_LOW)
//   active_o      : channel is in UP or DOWN
module led_fade_chan
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                lvl_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                active_o
);

  localparam logic [PWM_BITS-1:0] DutyMax = {PWM_BITS{1'b1}};
  localparam logic                LedOff  = ACTIVE_LOW;

  logic [PWM_BITS-1:0] d_q, d_d;
  chan_state_e         state_q, state_d;
  logic                led_q, led_d;
  logic                lit;

  // Saturating step; a level change mid-ramp simply reverses from the current duty.
  always_comb begin
    d_d = d_q;
    if (tick_i) begin
      if (lvl_i && (d_q != DutyMax)) begin
        d_d = d_q + PWM_BITS'(1);
      end else if (!lvl_i && (d_q != '0)) begin
        d_d = d_q - PWM_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d = next_state(d_d == '0, d_d == DutyMax, lvl_i);
  end

  // Full duty is lit on every PWM cycle, including the count that equals MAX.
  always_comb begin
    lit   = (pwm_cnt_i < d_q) || (d_q == DutyMax);
    led_d = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q     <= '0;
      state_q <= StOff;
      led_q   <= LedOff;
    end else begin
      d_q     <= d_d;
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  assign led_o    = led_q;
  assign active_o = (state_q == StUp) || (state_q == StDown);

endmodule

// File: rtl/led_fade.sv
// Three-channel LED fader: shared PWM counter and fade-step prescaler feeding
// three independent channels.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : en / lvl_r,g,b in; led_r,g,b / busy out (all outputs registered)
module led_fade
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 65536,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  led_fade_if.slave    bus
);

  localparam int unsigned         PresW   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PresW-1:0]    PresMax = PresW'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PresW-1:0]    presc_q, presc_d;
  logic                tick;
  logic                busy_q, busy_d;
  logic                act_r, act_g, act_b;

  // Tick is gated by en so a prescaler frozen at its last value cannot re-fire.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    tick      = bus.en && (presc_q == PresMax);
    presc_d   = presc_q;
    if (bus.en) begin
      presc_d = (presc_q == PresMax) ? '0 : presc_q + PresW'(1);
    end
    busy_d = act_r | act_g | act_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy = busy_q;

  led_fade_chan #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_chan_r (
    .clk_i     (clk),
    .rst_ni    (rst),
    .tick_i    (tick),
    .lvl_i     (bus.lvl_r),
    .pwm_cnt_i (pwm_cnt_q),
    .led_o     (bus.led_r),
    .active_o  (act_r)
  );

  led_fade_chan #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_chan_g (
    .clk_i     (clk),
    .rst_ni    (rst),
    .tick_i    (tick),
    .lvl_i     (bus.lvl_g),
    .pwm_cnt_i (pwm_cnt_q),
    .led_o     (bus.led_g),
    .active_o  (act_g)
  );

  led_fade_chan #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_chan_b (
    .clk_i     (clk),
    .rst_ni    (rst),
    .tick_i    (tick),
    .lvl_i     (bus.lvl_b),
    .pwm_cnt_i (pwm_cnt_q),
    .led_o     (bus.led_b),
    .active_o  (act_b)
  );

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade (PWM_BITS=4, STEP_DIV=4, ACTIVE_LOW=1): directed scenarios
// plus randomized level/enable/reset traffic, every cycle compared against a
// behavioural model of duty ramps and PWM waveforms.
module tb_led_fade;

  localparam int Bits = 4;
  localparam int Div  = 4;
  localparam int Max  = (1 << Bits) - 1;

  logic clk;
  logic rst;
  led_fade_if bus ();

  led_fade #(
    .PWM_BITS   (Bits),
    .STEP_DIV   (Div),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model.
  int m_pwm;
  int m_en_edges;
  int m_d     [3];
  bit m_ramp  [3];
  bit m_led   [3];
  bit m_busy;

  task automatic check_eq(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit lvl_of(int c);
    case (c)
      0:       return bus.lvl_r;
      1:       return bus.lvl_g;
      default: return bus.lvl_b;
    endcase
  endfunction

  function automatic void model_reset();
    m_pwm      = 0;
    m_en_edges = 0;
    m_busy     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_d[c]    = 0;
      m_ramp[c] = 1'b0;
      m_led[c]  = 1'b1;
    end
  endfunction

  // One rising edge of the reference: outputs from pre-edge values, then update.
  function automatic void model_edge();
    bit tick;
    bit lv;
    if (!rst) begin
      model_reset();
      return;
    end
    m_busy = m_ramp[0] | m_ramp[1] | m_ramp[2];
    for (int c = 0; c < 3; c++) begin
      m_led[c] = !((m_d[c] == Max) || (m_pwm < m_d[c]));
    end
    tick = 1'b0;
    if (bus.en) begin
      tick = ((m_en_edges % Div) == Div - 1);
      m_en_edges++;
    end
    m_pwm = (m_pwm + 1) % (Max + 1);
    for (int c = 0; c < 3; c++) begin
      lv = lvl_of(c);
      if (tick) begin
        if (lv) m_d[c] = (m_d[c] < Max) ? m_d[c] + 1 : Max;
        else    m_d[c] = (m_d[c] > 0)   ? m_d[c] - 1 : 0;
      end
      m_ramp[c] = lv ? (m_d[c] != Max) : (m_d[c] != 0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("led_r", bus.led_r, m_led[0]);
    check_eq("led_g", bus.led_g, m_led[1]);
    check_eq("led_b", bus.led_b, m_led[2]);
    check_eq("busy",  bus.busy,  m_busy);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_d(int c, int val, int budget, string tag);
    for (int i = 0; i < budget && m_d[c] != val; i++) step();
    check_eq(tag, m_d[c], val);
  endtask

  // Count cycles with led_r driven low (lit) over a 16-cycle PWM period.
  task automatic count_lit_r(output int lit);
    lit = 0;
    for (int i = 0; i < Max + 1; i++) begin
      step();
      if (bus.led_r == 1'b0) lit++;
    end
  endtask

  task automatic set_lvl(bit r, bit g, bit b);
    bus.lvl_r = r;
    bus.lvl_g = g;
    bus.lvl_b = b;
  endtask

  int lit;

  initial begin
    rst    = 1'b0;
    bus.en = 1'b0;
    set_lvl(1'b0, 1'b0, 1'b0);
    model_reset();

    // Reset state.
    steps(3);
    check_eq("reset_led_r", bus.led_r, 1);
    check_eq("reset_busy", bus.busy, 0);
    rst = 1'b1;

    // Ramp red up to full.
    bus.en = 1'b1;
    set_lvl(1'b1, 1'b0, 1'b0);
    step();
    step();
    check_eq("ramp_busy_set", bus.busy, 1);
    run_until_d(0, Max, 70, "ramp_up_reached_max");
    steps(4);
    check_eq("ramp_busy_clear", bus.busy, 0);
    count_lit_r(lit);
    check_eq("full_on_lit_cycles", lit, 16);

    // Ramp down; freeze at d=8 and measure duty.
    bus.lvl_r = 1'b0;
    run_until_d(0, 8, 40, "ramp_down_to_8");
    bus.en = 1'b0;
    count_lit_r(lit);
    check_eq("duty8_lit_cycles", lit, 8);
    bus.en = 1'b1;
    run_until_d(0, 0, 40, "ramp_down_to_0");
    steps(4);

    // Reverse mid-ramp at d=6: next tick gives 5.
    bus.lvl_r = 1'b1;
    run_until_d(0, 6, 40, "ramp_up_to_6");
    bus.lvl_r = 1'b0;
    run_until_d(0, 5, 8, "reverse_to_5");
    bus.en = 1'b0;
    count_lit_r(lit);
    check_eq("reverse_duty5_lit", lit, 5);
    check_eq("reverse_busy", bus.busy, 1);

    // Freeze at d=7 for 100 cycles.
    bus.en    = 1'b1;
    bus.lvl_r = 1'b1;
    run_until_d(0, 7, 20, "ramp_to_7");
    bus.en = 1'b0;
    steps(84);
    count_lit_r(lit);
    check_eq("frozen_duty7_lit", lit, 7);
    check_eq("frozen_busy", bus.busy, 1);

    // Asynchronous reset mid-cycle at d=10.
    bus.en = 1'b1;
    run_until_d(0, 10, 20, "ramp_to_10");
    set_lvl(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_led_r", bus.led_r, 1);
    check_eq("async_rst_led_g", bus.led_g, 1);
    check_eq("async_rst_led_b", bus.led_b, 1);
    check_eq("async_rst_busy", bus.busy, 0);
    model_reset();
    @(negedge clk);
    steps(2);
    set_lvl(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    run_until_d(0, 1, 8, "post_reset_d1");
    bus.en = 1'b0;
    count_lit_r(lit);
    check_eq("post_reset_duty1_lit", lit, 1);

    // Simultaneous r/b ramp with g off.
    rst = 1'b0;
    step();
    rst    = 1'b1;
    bus.en = 1'b1;
    set_lvl(1'b1, 1'b0, 1'b1);
    steps(40);
    check_eq("lockstep_led_g_off", bus.led_g, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.lvl_r = 1'($urandom());
      if ($urandom_range(0, 15) == 0) bus.lvl_g = 1'($urandom());
      if ($urandom_range(0, 15) == 0) bus.lvl_b = 1'($urandom());
      bus.en = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;
    steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
